// File: rtl/ram_pkg.sv
// Shared constants and types for the two-port arbitrated RAM.
package ram_pkg;

   // Conflict-resolution modes
   localparam int PRIO_RR      = 0;
   localparam int PRIO_FIXED_A = 1;

   // Supported read latencies, in cycles from accept to read data
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   // Identifies a requester, both for the current grant and the last grant
   typedef enum logic {
      GNT_A = 1'b0,
      GNT_B = 1'b1
   } grant_e;

endpackage

// File: rtl/arb_ram_if.sv
// Request/response bundle for both requester ports of arb_ram.
interface arb_ram_if #(
   parameter int AddrBits = 16,
   parameter int DataBits = 8
) ();

   logic                a_req;
   logic                a_we;
   logic [AddrBits-1:0] a_addr;
   logic [DataBits-1:0] a_wdata;
   logic                a_ack;
   logic                a_rvalid;
   logic [DataBits-1:0] a_rdata;

   logic                b_req;
   logic                b_we;
   logic [AddrBits-1:0] b_addr;
   logic [DataBits-1:0] b_wdata;
   logic                b_ack;
   logic                b_rvalid;
   logic [DataBits-1:0] b_rdata;

   // Requester side
   modport master (
      output a_req, a_we, a_addr, a_wdata,
      input  a_ack, a_rvalid, a_rdata,
      output b_req, b_we, b_addr, b_wdata,
      input  b_ack, b_rvalid, b_rdata
   );

   // Memory side
   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      output a_ack, a_rvalid, a_rdata,
      input  b_req, b_we, b_addr, b_wdata,
      output b_ack, b_rvalid, b_rdata
   );

endinterface

// File: rtl/arb2.sv
// Two-requester arbiter: combinational grants, registered last-grant state.
module arb2
   import ram_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req_a,
   input  logic req_b,
   input  logic mode,    // 1: A always wins a conflict, 0: round-robin
   output logic gnt_a,
   output logic gnt_b
);

   grant_e last_q;
   grant_e last_d;

   // Grant decision: a lone requester wins outright, a conflict goes by mode
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (!reset) begin
         if (req_a && req_b) begin
            if (mode || (last_q == GNT_B)) begin
               gnt_a = 1'b1;
            end else begin
               gnt_b = 1'b1;
            end
         end else begin
            gnt_a = req_a;
            gnt_b = req_b;
         end
      end
   end

   // A grant is always an accept, so last-grant follows whichever grant fired
   always_comb begin
      last_d = last_q;
      if (gnt_a) begin
         last_d = GNT_A;
      end else if (gnt_b) begin
         last_d = GNT_B;
      end
   end

   // Reset to "B granted last" so A wins the first round-robin conflict
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= GNT_B;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/arb_ram.sv
// Single-array RAM shared by two requesters through a two-way arbiter,
// with a fixed-latency read return path tagged by port.
module arb_ram
   import ram_pkg::*;
#(
   parameter int AddrBits    = 16,
   parameter int DataBits    = 8,
   parameter int ReadLatency = 1,
   parameter int Priority    = PRIO_RR
) (
   input  logic     clk,
   input  logic     reset,
   arb_ram_if.slave bus
);

   localparam int Words = 1 << AddrBits;

   logic                gnt_a;
   logic                gnt_b;
   logic                acc;
   logic                acc_we;
   grant_e              acc_port;
   logic [AddrBits-1:0] acc_addr;
   logic [DataBits-1:0] acc_wdata;
   logic [DataBits-1:0] mem_rdata;
   logic                rd_vld_p0;

   logic [DataBits-1:0] mem [Words];

   arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req_a (bus.a_req),
      .req_b (bus.b_req),
      .mode  (Priority == PRIO_FIXED_A),
      .gnt_a (gnt_a),
      .gnt_b (gnt_b)
   );

   assign bus.a_ack = gnt_a;
   assign bus.b_ack = gnt_b;

   // Steer the granted port onto the single memory access path
   always_comb begin
      acc       = gnt_a | gnt_b;
      acc_port  = gnt_b ? GNT_B : GNT_A;
      acc_we    = gnt_b ? bus.b_we    : bus.a_we;
      acc_addr  = gnt_b ? bus.b_addr  : bus.a_addr;
      acc_wdata = gnt_b ? bus.b_wdata : bus.a_wdata;
   end

   // Write lands at the accept edge; contents survive reset
   always_ff @(posedge clk) begin
      if (acc && acc_we) begin
         mem[acc_addr] <= acc_wdata;
      end
   end

   assign mem_rdata = mem[acc_addr];
   assign rd_vld_p0 = acc & ~acc_we;

   // Final-stage inputs: either straight from the accept cycle or one stage later
   logic                fin_vld_d;
   grant_e              fin_port_d;
   logic [DataBits-1:0] fin_data_d;

   if (ReadLatency == RD_LAT_MAX) begin : g_lat2
      logic                vld_p1_d;
      logic                vld_p1_q;
      grant_e              port_p1_d;
      grant_e              port_p1_q;
      logic [DataBits-1:0] data_p1_d;
      logic [DataBits-1:0] data_p1_q;

      // p0 -> p1: capture the read at its accept edge
      always_comb begin
         vld_p1_d  = rd_vld_p0;
         port_p1_d = acc_port;
         data_p1_d = mem_rdata;
      end

      // Only the valid bit is cleared; in-flight tag and data are don't-care
      always_ff @(posedge clk) begin
         if (reset) begin
            vld_p1_q <= 1'b0;
         end else begin
            vld_p1_q <= vld_p1_d;
         end
         port_p1_q <= port_p1_d;
         data_p1_q <= data_p1_d;
      end

      assign fin_vld_d  = vld_p1_q;
      assign fin_port_d = port_p1_q;
      assign fin_data_d = data_p1_q;
   end else begin : g_lat1
      assign fin_vld_d  = rd_vld_p0;
      assign fin_port_d = acc_port;
      assign fin_data_d = mem_rdata;
   end

   logic                fin_vld_q;
   grant_e              fin_port_q;
   logic [DataBits-1:0] a_rdata_d;
   logic [DataBits-1:0] a_rdata_q;
   logic [DataBits-1:0] b_rdata_d;
   logic [DataBits-1:0] b_rdata_q;

   // Per-port read data holds until that port's next return
   always_comb begin
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      if (fin_vld_d && (fin_port_d == GNT_A)) begin
         a_rdata_d = fin_data_d;
      end
      if (fin_vld_d && (fin_port_d == GNT_B)) begin
         b_rdata_d = fin_data_d;
      end
   end

   // Output stage: reset drops any return still in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         fin_vld_q <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         fin_vld_q <= fin_vld_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
      end
      fin_port_q <= fin_port_d;
   end

   // Outputs are forced quiet during the reset cycle itself, since the
   // registers only clear at the edge that ends it
   assign bus.a_rvalid = fin_vld_q & (fin_port_q == GNT_A) & ~reset;
   assign bus.b_rvalid = fin_vld_q & (fin_port_q == GNT_B) & ~reset;
   assign bus.a_rdata  = reset ? '0 : a_rdata_q;
   assign bus.b_rdata  = reset ? '0 : b_rdata_q;

endmodule

// File: tb/tb_arb_ram.sv
// Bench for arb_ram: three instances (RR/lat1, fixed/lat1, RR/lat2) driven
// by directed steps, with a scoreboard tracking every read return.
module tb_arb_ram;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   logic [2:0]  a_req, a_we, b_req, b_we;
   logic [15:0] a_addr [3];
   logic [15:0] b_addr [3];
   logic [7:0]  a_wdata [3];
   logic [7:0]  b_wdata [3];
   wire  [2:0]  a_ack, b_ack, a_rvalid, b_rvalid;
   wire  [7:0]  a_rdata [3];
   wire  [7:0]  b_rdata [3];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      arb_ram_if #(.AddrBits(16), .DataBits(8)) bus ();
      assign bus.a_req   = a_req[g];
      assign bus.a_we    = a_we[g];
      assign bus.a_addr  = a_addr[g];
      assign bus.a_wdata = a_wdata[g];
      assign bus.b_req   = b_req[g];
      assign bus.b_we    = b_we[g];
      assign bus.b_addr  = b_addr[g];
      assign bus.b_wdata = b_wdata[g];
      assign a_ack[g]    = bus.a_ack;
      assign a_rvalid[g] = bus.a_rvalid;
      assign a_rdata[g]  = bus.a_rdata;
      assign b_ack[g]    = bus.b_ack;
      assign b_rvalid[g] = bus.b_rvalid;
      assign b_rdata[g]  = bus.b_rdata;

      arb_ram #(
         .AddrBits    (16),
         .DataBits    (8),
         .ReadLatency ((g == 2) ? 2 : 1),
         .Priority    ((g == 1) ? 1 : 0)
      ) dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus)
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_a(input int d, input logic req, input logic we,
                        input logic [15:0] addr, input logic [7:0] wd);
      a_req[d] = req; a_we[d] = we; a_addr[d] = addr; a_wdata[d] = wd;
   endtask

   task automatic set_b(input int d, input logic req, input logic we,
                        input logic [15:0] addr, input logic [7:0] wd);
      b_req[d] = req; b_we[d] = we; b_addr[d] = addr; b_wdata[d] = wd;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: reads pushed at accept with their due cycle, popped on return
   typedef struct {
      int         d;
      int         p;
      int         due;
      logic [7:0] data;
   } sb_t;

   sb_t        sbq [$];
   logic [7:0] mdl [int];
   logic [7:0] last_rd [6];

   always @(negedge clk) begin
      logic       rv, ack, req, we;
      logic [7:0] rd, wd;
      logic [15:0] ad;
      int         found, key, rl;
      string      nm;
      for (int d = 0; d < 3; d++) begin
         rl = (d == 2) ? 2 : 1;
         chk($sformatf("d%0d_ack_onehot", d), a_ack[d] & b_ack[d], 0);
         for (int p = 0; p < 2; p++) begin
            nm  = $sformatf("d%0d_%s", d, (p == 1) ? "b" : "a");
            rv  = (p == 1) ? b_rvalid[d] : a_rvalid[d];
            rd  = (p == 1) ? b_rdata[d]  : a_rdata[d];
            ack = (p == 1) ? b_ack[d]    : a_ack[d];
            req = (p == 1) ? b_req[d]    : a_req[d];
            we  = (p == 1) ? b_we[d]     : a_we[d];
            ad  = (p == 1) ? b_addr[d]   : a_addr[d];
            wd  = (p == 1) ? b_wdata[d]  : a_wdata[d];
            if (reset) begin
               chk({nm, "_rst_ack"}, ack, 0);
               chk({nm, "_rst_rvalid"}, rv, 0);
               chk({nm, "_rst_rdata"}, rd, 0);
               last_rd[d*2+p] = 8'h00;
            end else begin
               found = -1;
               for (int i = 0; i < sbq.size(); i++)
                  if (sbq[i].d == d && sbq[i].p == p && sbq[i].due == cyc) found = i;
               chk({nm, "_sb_rvalid"}, rv, found >= 0);
               if (found >= 0) begin
                  chk({nm, "_sb_rdata"}, rd, sbq[found].data);
                  last_rd[d*2+p] = sbq[found].data;
                  sbq.delete(found);
               end else begin
                  chk({nm, "_rdata_hold"}, rd, last_rd[d*2+p]);
               end
               chk({nm, "_ack_wo_req"}, ack & ~req, 0);
               if (ack && req) begin
                  key = d * 65536 + int'(ad);
                  if (we) mdl[key] = wd;
                  else sbq.push_back('{d: d, p: p, due: cyc + rl, data: mdl[key]});
               end
            end
         end
      end
      if (reset) sbq.delete();
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      a_req = '1; b_req = '1; a_we = '0; b_we = '0;
      for (int d = 0; d < 3; d++) begin
         a_addr[d] = 16'h0000; b_addr[d] = 16'h0000;
         a_wdata[d] = 8'h00;   b_wdata[d] = 8'h00;
      end

      // Reset held 3 cycles with both ports requesting
      for (int i = 0; i < 3; i++) begin
         smp();
         for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst%0d_d%0d_ack", i, d), {a_ack[d], b_ack[d]}, 0);
            chk($sformatf("rst%0d_d%0d_rv", i, d), {a_rvalid[d], b_rvalid[d]}, 0);
            chk($sformatf("rst%0d_d%0d_rd", i, d), {a_rdata[d], b_rdata[d]}, 0);
         end
         nxt();
      end
      reset = 1'b0;
      a_req = '0; b_req = '0;

      // dut2: first conflict after reset goes to A; also preloads
      set_a(2, 1, 1, 16'h0000, 8'h11); set_b(2, 1, 1, 16'hFFFF, 8'h33);
      smp(); chk("d2_first_conflict_a", {a_ack[2], b_ack[2]}, 2'b10); nxt();
      set_a(2, 0, 0, 16'h0000, 8'h00);
      smp(); chk("d2_b_after_a", b_ack[2], 1); nxt();
      set_b(2, 0, 0, 16'h0000, 8'h00); set_a(2, 1, 1, 16'h0001, 8'h22);
      smp(); chk("d2_wr1_ack", a_ack[2], 1); nxt();

      // dut2 latency 2: three back-to-back reads
      set_a(2, 1, 0, 16'h0000, 8'h00);
      smp(); chk("l2_c0_ack", a_ack[2], 1); chk("l2_c0_rv", a_rvalid[2], 0); nxt();
      set_a(2, 1, 0, 16'h0001, 8'h00);
      smp(); chk("l2_c1_ack", a_ack[2], 1); chk("l2_c1_rv", a_rvalid[2], 0); nxt();
      set_a(2, 1, 0, 16'hFFFF, 8'h00);
      smp(); chk("l2_c2_rv", a_rvalid[2], 1); chk("l2_c2_rd", a_rdata[2], 8'h11); nxt();
      set_a(2, 0, 0, 16'h0000, 8'h00);
      smp(); chk("l2_c3_rv", a_rvalid[2], 1); chk("l2_c3_rd", a_rdata[2], 8'h22); nxt();
      smp(); chk("l2_c4_rv", a_rvalid[2], 1); chk("l2_c4_rd", a_rdata[2], 8'h33); nxt();
      smp(); chk("l2_c5_rv", a_rvalid[2], 0); chk("l2_c5_hold", a_rdata[2], 8'h33); nxt();

      // dut0: A writes, B reads the same word next cycle
      set_a(0, 1, 1, 16'h1234, 8'h5A);
      smp(); chk("wr_rd_a_ack", a_ack[0], 1); nxt();
      set_a(0, 0, 0, 16'h0000, 8'h00); set_b(0, 1, 0, 16'h1234, 8'h00);
      smp(); chk("wr_rd_b_ack", {a_ack[0], b_ack[0]}, 2'b01); nxt();
      set_b(0, 0, 0, 16'h0000, 8'h00);
      smp(); chk("wr_rd_b_rv", b_rvalid[0], 1); chk("wr_rd_b_rd", b_rdata[0], 8'h5A); nxt();
      smp(); chk("wr_rd_b_rv_end", b_rvalid[0], 0); chk("wr_rd_b_hold", b_rdata[0], 8'h5A); nxt();

      // dut0: preload via B (leaves B as last grant), then 6 cycles of contention
      set_b(0, 1, 1, 16'h0010, 8'hA1);
      smp(); chk("pre0_ack", b_ack[0], 1); nxt();
      set_b(0, 1, 1, 16'h0020, 8'hB2);
      smp(); chk("pre1_ack", b_ack[0], 1); nxt();
      set_a(0, 1, 0, 16'h0010, 8'h00); set_b(0, 1, 0, 16'h0020, 8'h00);
      for (int i = 0; i < 7; i++) begin
         if (i == 6) begin
            set_a(0, 0, 0, 16'h0000, 8'h00); set_b(0, 0, 0, 16'h0000, 8'h00);
         end
         smp();
         chk($sformatf("rr%0d_a_ack", i), a_ack[0], (i < 6) && (i % 2 == 0));
         chk($sformatf("rr%0d_b_ack", i), b_ack[0], (i < 6) && (i % 2 == 1));
         chk($sformatf("rr%0d_a_rv", i), a_rvalid[0], (i >= 1) && ((i - 1) % 2 == 0));
         chk($sformatf("rr%0d_b_rv", i), b_rvalid[0], (i >= 1) && ((i - 1) % 2 == 1));
         if (i >= 1) chk($sformatf("rr%0d_a_rd", i), a_rdata[0], 8'hA1);
         if (i >= 2) chk($sformatf("rr%0d_b_rd", i), b_rdata[0], 8'hB2);
         nxt();
      end

      // dut1 fixed priority: A holds the port while it requests
      set_a(1, 1, 1, 16'h0040, 8'h44); set_b(1, 1, 1, 16'h0050, 8'h77);
      for (int i = 0; i < 4; i++) begin
         smp(); chk($sformatf("fix%0d_acks", i), {a_ack[1], b_ack[1]}, 2'b10); nxt();
      end
      set_a(1, 0, 0, 16'h0000, 8'h00);
      smp(); chk("fix_b_after_drop", {a_ack[1], b_ack[1]}, 2'b01); nxt();
      set_b(1, 0, 0, 16'h0000, 8'h00); set_a(1, 1, 0, 16'h0050, 8'h00);
      smp(); chk("fix_rd_ack", a_ack[1], 1); nxt();
      set_a(1, 0, 0, 16'h0000, 8'h00);
      smp(); chk("fix_rd_rv", a_rvalid[1], 1); chk("fix_rd_rd", a_rdata[1], 8'h77); nxt();

      // Reads in flight on dut0 and dut2 when reset arrives
      set_a(0, 1, 1, 16'h0300, 8'hC3);
      smp(); chk("rr_wr_ack", a_ack[0], 1); nxt();
      set_a(0, 1, 0, 16'h0300, 8'h00); set_a(2, 1, 0, 16'h0001, 8'h00);
      smp(); chk("flight_acks", {a_ack[0], a_ack[2]}, 2'b11); nxt();
      set_a(0, 0, 0, 16'h0000, 8'h00); set_a(2, 0, 0, 16'h0000, 8'h00);
      reset = 1'b1;
      smp(); chk("flight_rst0_rv", {a_rvalid[0], a_rvalid[2]}, 2'b00); nxt();
      smp(); chk("flight_rst1_rv", {a_rvalid[0], a_rvalid[2]}, 2'b00); nxt();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         smp(); chk($sformatf("post_rst%0d_rv", i), {a_rvalid[0], a_rvalid[2]}, 2'b00); nxt();
      end

      // Memory survives reset
      set_a(0, 1, 0, 16'h0300, 8'h00); set_a(2, 1, 0, 16'h0000, 8'h00);
      smp(); chk("keep_acks", {a_ack[0], a_ack[2]}, 2'b11); nxt();
      set_a(0, 0, 0, 16'h0000, 8'h00); set_a(2, 0, 0, 16'h0000, 8'h00);
      smp(); chk("keep_d0_rv", a_rvalid[0], 1); chk("keep_d0_rd", a_rdata[0], 8'hC3); nxt();
      smp(); chk("keep_d2_rv", a_rvalid[2], 1); chk("keep_d2_rd", a_rdata[2], 8'h11); nxt();
      smp(); nxt();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
